interrupt_controller: RTL

Parametrised multi-source successor to the single-line interrupt hold register. It sits between the external interrupt pins, the hazard unit and the fetch stage. It latches rising edges on `N_IRQ` request lines into a pending register and applies a per-source mask. It arbitrates by fixed priority (lowest index wins), presents one request to fetch together with a per-source vector, and tracks the in-service handler until return-from-interrupt retires.

---
 rtl/interrupt_controller.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-latched, maskable, fixed-priority interrupt
// controller. Lowest eligible index wins. One request at a time is presented
// to fetch with its handler vector, and the in-service handler is tracked
// until return-from-interrupt retires.
// Optional build macro: IRQ_NEST_EN enables one level of preemption by a
// strictly higher-priority (lower-index) source during SERVICE.
module interrupt_controller #(
    parameter int              N_IRQ      = 4,
    parameter int              VEC_W      = 32,
    parameter logic [VEC_W-1:0] VEC_BASE  = '0,
    parameter int              VEC_STRIDE = 2,
    localparam int             ID_W       = $clog2(N_IRQ)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [N_IRQ-1:0]  i_irq,
    input  logic              i_mask_wr,
    input  logic [N_IRQ-1:0]  i_mask_data,
    input  logic              i_stall,
    input  logic              i_ack,
    input  logic              i_rti,
    output logic              o_call,
    output logic [VEC_W-1:0]  o_vector,
    output logic [ID_W-1:0]   o_id,
    output logic [N_IRQ-1:0]  o_pending,
    output logic              o_in_service
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t            state_q;
    logic [ID_W-1:0]   id_q;
    logic [VEC_W-1:0]  vec_q;
    logic [N_IRQ-1:0]  pending_q, pending_d;
    logic [N_IRQ-1:0]  prev_q;
    logic [N_IRQ-1:0]  mask_q;
    logic [N_IRQ-1:0]  rise;
    logic [N_IRQ-1:0]  elig;
    logic [N_IRQ-1:0]  clr;
    logic [ID_W-1:0]   sel_id;
    logic              any_elig;
    logic              take;

`ifdef IRQ_NEST_EN
    logic [ID_W-1:0]   save_id_q;
    logic              nested_q;
`endif

    // Handler address for a source; wraps modulo 2^VEC_W.
    function automatic logic [VEC_W-1:0] vec_of(input logic [ID_W-1:0] idx);
        return VEC_BASE + (VEC_W'(idx) * VEC_W'(VEC_STRIDE));
    endfunction

    assign rise     = i_irq & ~prev_q;
    assign elig     = pending_q & ~mask_q;
    assign any_elig = |elig;
    assign o_call   = (state_q == S_REQ) && !i_stall;
    // An ack only counts while the call is actually visible to fetch.
    assign take     = o_call && i_ack;

    // Fixed priority: scan from the top so the lowest eligible index wins.
    always_comb begin
        sel_id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) sel_id = ID_W'(i);
        end
    end

    // Pending next state: an accepted ack clears the served bit, a new edge sets (set wins).
    always_comb begin
        clr = '0;
        if (take) clr[id_q] = 1'b1;
        pending_d = (pending_q & ~clr) | rise;
    end

    // Edge-detect history, pending and mask registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            prev_q    <= '1;
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            prev_q    <= i_irq;
            pending_q <= pending_d;
            if (i_mask_wr) mask_q <= i_mask_data;
        end
    end

    // Request/service state machine with registered id and vector.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            id_q      <= '0;
            vec_q     <= VEC_BASE;
`ifdef IRQ_NEST_EN
            save_id_q <= '0;
            nested_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_elig) begin
                        id_q    <= sel_id;
                        vec_q   <= vec_of(sel_id);
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (take) state_q <= S_SERVICE;
                end
                S_SERVICE: begin
`ifdef IRQ_NEST_EN
                    if (i_rti) begin
                        if (nested_q) begin
                            id_q     <= save_id_q;
                            vec_q    <= vec_of(save_id_q);
                            nested_q <= 1'b0;
                        end else begin
                            state_q  <= S_IDLE;
                        end
                    end else if (!nested_q && any_elig && (sel_id < id_q)) begin
                        save_id_q <= id_q;
                        nested_q  <= 1'b1;
                        id_q      <= sel_id;
                        vec_q     <= vec_of(sel_id);
                        state_q   <= S_REQ;
                    end
`else
                    if (i_rti) state_q <= S_IDLE;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_vector  = vec_q;
    assign o_id      = id_q;
    assign o_pending = pending_q;
`ifdef IRQ_NEST_EN
    assign o_in_service = (state_q == S_SERVICE) || nested_q;
`else
    assign o_in_service = (state_q == S_SERVICE);
`endif

endmodule
